// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - HI/LO-class funct codes and multiply/divide FSM state encoding
package mips_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - shared accumulator/counter datapath for shift-add multiply and restoring divide
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                div_i,
    input  logic                run_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic                last_o,
    output logic [2*XLEN-1:0]   acc_o
);

    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              div_q, div_d;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;

    // Multiply keeps the multiplier in the low half and shifts the partial product in from the top;
    // divide keeps the dividend in the low half and shifts quotient bits in from the bottom.
    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opnd_q};
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        if (start_i) begin
            acc_d  = div_i ? {{XLEN{1'b0}}, a_i} : {{XLEN{1'b0}}, b_i};
            opnd_d = div_i ? b_i : a_i;
            div_d  = div_i;
            cnt_d  = CW'(XLEN);
        end else if (run_i) begin
            cnt_d = cnt_q - 1'b1;
            if (div_q) begin
                if (!rem_diff[XLEN]) begin
                    acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
            end else if (acc_q[0]) begin
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
        end
    end

    assign last_o = (cnt_q == CW'(1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - MIPS HI/LO multiply/divide unit; MULDIV_SINGLE_CYCLE_MUL_EN selects combinational multiply
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [5:0]      Funct,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            busy,
    output logic            stall,
    output logic [XLEN-1:0] hilo_rdata,
    output logic [XLEN-1:0] hi_q,
    output logic [XLEN-1:0] lo_q
);

    muldiv_state_e     state_q, state_d;
    logic [XLEN-1:0]   hi_d, lo_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic              isdiv_q, isdiv_d;
    logic              core_start, core_div, core_last;
    logic [2*XLEN-1:0] core_acc;
    logic              is_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;

    assign is_signed = (Funct == FUNCT_MULT) || (Funct == FUNCT_DIV);
    assign a_neg     = is_signed && in_a[XLEN-1];
    assign b_neg     = is_signed && in_b[XLEN-1];
    assign a_mag     = a_neg ? -in_a : in_a;
    assign b_mag     = b_neg ? -in_b : in_b;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    logic [2*XLEN-1:0] fast_mag;
    assign fast_mag = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (core_start),
        .div_i   (core_div),
        .run_i   ((state_q == ST_MUL) || (state_q == ST_DIV)),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .last_o  (core_last),
        .acc_o   (core_acc)
    );

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        isdiv_d    = isdiv_q;
        core_start = 1'b0;
        core_div   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (Funct)
                        FUNCT_MTHI: hi_d = in_a;
                        FUNCT_MTLO: lo_d = in_a;
                        FUNCT_MULT, FUNCT_MULTU: begin
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
                            {hi_d, lo_d} = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`else
                            qneg_d     = a_neg ^ b_neg;
                            dz_d       = 1'b0;
                            isdiv_d    = 1'b0;
                            core_start = 1'b1;
                            state_d    = ST_MUL;
`endif
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            isdiv_d = 1'b1;
                            dz_d    = (in_b == '0);
                            if (in_b == '0) begin
                                state_d = ST_FIX;
                            end else begin
                                core_start = 1'b1;
                                core_div   = 1'b1;
                                state_d    = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (core_last) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                // Divide by zero passes through FIX only to give the pipeline a one-cycle stall.
                if (!dz_q) begin
                    if (isdiv_q) begin
                        lo_d = qneg_q ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
                        hi_d = rneg_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
                    end else begin
                        {hi_d, lo_d} = qneg_q ? -core_acc : core_acc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            isdiv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            isdiv_q <= isdiv_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign stall      = op_valid && busy;
    assign hilo_rdata = (Funct == FUNCT_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_BUSY = 33;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            op_valid = 1'b0;
    logic [5:0]      Funct = 6'h00;
    logic [XLEN-1:0] in_a = '0;
    logic [XLEN-1:0] in_b = '0;
    logic            busy;
    logic            stall;
    logic [XLEN-1:0] hilo_rdata;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .Funct      (Funct),
        .in_a       (in_a),
        .in_b       (in_b),
        .busy       (busy),
        .stall      (stall),
        .hilo_rdata (hilo_rdata),
        .hi_q       (hi_q),
        .lo_q       (lo_q)
    );

    // Presents one op for a single cycle, then counts busy cycles until the unit is idle again.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int bcnt);
        @(posedge clk); #1;
        op_valid = 1'b1; Funct = f; in_a = a; in_b = b;
        @(posedge clk); #1;
        op_valid = 1'b0; Funct = 6'h00; in_a = '0; in_b = '0;
        bcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            bcnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b1; Funct = F_MULT;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
        tests_run++; if (hi_q !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", hi_q); end
        tests_run++; if (lo_q !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", lo_q); end
        tests_run++; if (hilo_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", hilo_rdata); end
        op_valid = 1'b0; Funct = 6'h00;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_mthi_mtlo();
        int bc;
        run_op(F_MTHI, 32'h0000_0011, 32'hFFFF_FFFF, bc);
        tests_run++; if (bc !== 0) begin tests_failed++; $display("FAIL mthi_busy: got %0d expected 0", bc); end
        tests_run++; if (hi_q !== 32'h11) begin tests_failed++; $display("FAIL mthi_hi: got %h expected 00000011", hi_q); end
        run_op(F_MTLO, 32'h0000_0022, 32'h0, bc);
        tests_run++; if (lo_q !== 32'h22) begin tests_failed++; $display("FAIL mtlo_lo: got %h expected 00000022", lo_q); end
        tests_run++; if (hi_q !== 32'h11) begin tests_failed++; $display("FAIL mtlo_hi_kept: got %h expected 00000011", hi_q); end
        op_valid = 1'b1; Funct = F_MFHI; #1;
        tests_run++; if (hilo_rdata !== 32'h11) begin tests_failed++; $display("FAIL mfhi_rdata: got %h expected 00000011", hilo_rdata); end
        Funct = F_MFLO; #1;
        tests_run++; if (hilo_rdata !== 32'h22) begin tests_failed++; $display("FAIL mflo_rdata: got %h expected 00000022", hilo_rdata); end
        op_valid = 1'b0; Funct = 6'h00;
    endtask

    task automatic test_ignored_funct();
        int bc;
        run_op(6'h20, 32'hDEAD_BEEF, 32'h1234_5678, bc);
        tests_run++; if (bc !== 0) begin tests_failed++; $display("FAIL ignored_busy: got %0d expected 0", bc); end
        tests_run++; if ({hi_q, lo_q} !== 64'h11_0000_0022) begin tests_failed++; $display("FAIL ignored_hilo: got %h_%h expected 00000011_00000022", hi_q, lo_q); end
    endtask

    task automatic test_div_by_zero();
        int bc;
        run_op(F_DIVU, 32'h0000_0005, 32'h0, bc);
        tests_run++; if (bc !== 1) begin tests_failed++; $display("FAIL divzero_busy: got %0d expected 1", bc); end
        tests_run++; if ({hi_q, lo_q} !== 64'h11_0000_0022) begin tests_failed++; $display("FAIL divzero_hilo: got %h_%h expected 00000011_00000022", hi_q, lo_q); end
    endtask

    task automatic test_mult();
        int bc;
        run_op(F_MULT, 32'hFFFF_FFFE, 32'h0000_0003, bc);
        tests_run++; if (bc !== MUL_BUSY) begin tests_failed++; $display("FAIL mult_busy: got %0d expected %0d", bc, MUL_BUSY); end
        tests_run++; if ({hi_q, lo_q} !== 64'hFFFF_FFFF_FFFF_FFFA) begin tests_failed++; $display("FAIL mult_hilo: got %h_%h expected ffffffff_fffffffa", hi_q, lo_q); end
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
        tests_run++; if ({hi_q, lo_q} !== 64'hFFFF_FFFE_0000_0001) begin tests_failed++; $display("FAIL multu_hilo: got %h_%h expected fffffffe_00000001", hi_q, lo_q); end
        run_op(F_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFD, bc);
        tests_run++; if ({hi_q, lo_q} !== 64'h0000_0000_0000_0015) begin tests_failed++; $display("FAIL mult_negneg: got %h_%h expected 00000000_00000015", hi_q, lo_q); end
    endtask

    task automatic test_div();
        int bc;
        run_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, bc);
        tests_run++; if (bc !== DIV_BUSY) begin tests_failed++; $display("FAIL div_busy: got %0d expected %0d", bc, DIV_BUSY); end
        tests_run++; if ({hi_q, lo_q} !== 64'hFFFF_FFFF_FFFF_FFFD) begin tests_failed++; $display("FAIL div_neg_dividend: got %h_%h expected ffffffff_fffffffd", hi_q, lo_q); end
        run_op(F_DIV, 32'h0000_0007, 32'hFFFF_FFFE, bc);
        tests_run++; if ({hi_q, lo_q} !== 64'h0000_0001_FFFF_FFFD) begin tests_failed++; $display("FAIL div_neg_divisor: got %h_%h expected 00000001_fffffffd", hi_q, lo_q); end
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, bc);
        tests_run++; if ({hi_q, lo_q} !== 64'h0000_000F_0FFF_FFFF) begin tests_failed++; $display("FAIL divu_big: got %h_%h expected 0000000f_0fffffff", hi_q, lo_q); end
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
        tests_run++; if ({hi_q, lo_q} !== 64'h0000_0000_8000_0000) begin tests_failed++; $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", hi_q, lo_q); end
    endtask

    task automatic test_mflo_stall();
        int sc;
        logic [31:0] first_rdata;
        first_rdata = '0;
        @(posedge clk); #1;
        op_valid = 1'b1; Funct = F_MULTU; in_a = 32'h0001_0000; in_b = 32'h0001_0001;
        @(posedge clk); #1;
        Funct = F_MFLO; in_a = '0; in_b = '0;
        sc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            if (sc == 0) first_rdata = hilo_rdata;
            sc++;
        end
        tests_run++; if (sc !== MUL_BUSY) begin tests_failed++; $display("FAIL mflo_stall_cycles: got %0d expected %0d", sc, MUL_BUSY); end
        tests_run++; if (hilo_rdata !== 32'h0001_0000) begin tests_failed++; $display("FAIL mflo_release_rdata: got %h expected 00010000", hilo_rdata); end
        tests_run++; if (hi_q !== 32'h1) begin tests_failed++; $display("FAIL mflo_hi: got %h expected 00000001", hi_q); end
`ifndef MULDIV_SINGLE_CYCLE_MUL_EN
        tests_run++; if (first_rdata !== 32'h8000_0000) begin tests_failed++; $display("FAIL mflo_stale_rdata: got %h expected 80000000", first_rdata); end
`endif
        op_valid = 1'b0; Funct = 6'h00;
    endtask

    task automatic test_back_to_back();
        int sc;
        int bc;
        @(posedge clk); #1;
        op_valid = 1'b1; Funct = F_MULT; in_a = 32'h0000_0003; in_b = 32'h0000_0005;
        @(posedge clk); #1;
        Funct = F_DIVU; in_a = 32'd100; in_b = 32'd7;
        sc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            sc++;
        end
        tests_run++; if (sc !== MUL_BUSY) begin tests_failed++; $display("FAIL b2b_stall_cycles: got %0d expected %0d", sc, MUL_BUSY); end
        tests_run++; if ({hi_q, lo_q} !== 64'h0000_0000_0000_000F) begin tests_failed++; $display("FAIL b2b_mult_hilo: got %h_%h expected 00000000_0000000f", hi_q, lo_q); end
        @(posedge clk); #1;
        op_valid = 1'b0; Funct = 6'h00; in_a = '0; in_b = '0;
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            bc++;
        end
        tests_run++; if (bc !== DIV_BUSY) begin tests_failed++; $display("FAIL b2b_div_busy: got %0d expected %0d", bc, DIV_BUSY); end
        tests_run++; if ({hi_q, lo_q} !== 64'h0000_0002_0000_000E) begin tests_failed++; $display("FAIL b2b_div_hilo: got %h_%h expected 00000002_0000000e", hi_q, lo_q); end
    endtask

    task automatic test_reset_mid_div();
        @(posedge clk); #1;
        op_valid = 1'b1; Funct = F_DIV; in_a = 32'd1000; in_b = 32'd9;
        @(posedge clk); #1;
        op_valid = 1'b0; Funct = 6'h00; in_a = '0; in_b = '0;
        repeat (9) @(posedge clk);
        #2;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0; #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        tests_run++; if ({hi_q, lo_q} !== 64'h0) begin tests_failed++; $display("FAIL midreset_hilo: got %h_%h expected 00000000_00000000", hi_q, lo_q); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_no_resume: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_ignored_funct();
        test_div_by_zero();
        test_mult();
        test_div();
        test_mflo_stall();
        test_back_to_back();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle MIPS HI/LO execution unit in the EX stage, next to the ALU.
- Consumes R-type Funct codes the ALU does not handle: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- Mult and div are iterative, one bit per cycle. The unit raises a stall to the pipeline while busy.
- Owns the HI and LO architectural registers.

Parameters:
- XLEN, 32: operand and HI/LO width. Iteration count equals XLEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  EX-stage instruction is a HI/LO-class R-type
- Funct  in  6  instruction funct field
- in_a  in  XLEN  rs operand (forwarded)
- in_b  in  XLEN  rt operand (forwarded)
- busy  out  1  iterative operation in progress
- stall  out  1  op_valid && busy; freezes IF/ID/EX
- hilo_rdata  out  XLEN  HI or LO for mfhi/mflo
- hi_q  out  XLEN  current HI
- lo_q  out  XLEN  current LO

Behaviour:
- Funct codes: 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo. Any other code with op_valid is ignored, with no state change.
- States: IDLE, MUL, DIV, FIX.
- Reset: state=IDLE, HI=0, LO=0, counter=0, busy=0, stall=0, hilo_rdata=0.
- Accept rule: an operation is accepted only when op_valid && state==IDLE (cycle T). While busy, the upstream holds the same instruction and stall is high.
- mthi/mtlo: HI/LO take in_a at the edge ending cycle T. busy stays 0.
- mfhi/mflo: hilo_rdata is combinational from HI/LO; the value is valid in the same cycle.
- mfhi/mflo while busy: stall is asserted and hilo_rdata shows the stale value. The pipeline discards it because it is stalled.
- Iterative ops, capture at T:
  - Signed ops (mult, div) latch |in_a| and |in_b|, plus result-sign flags: product sign = a^b, quotient sign = a^b, remainder sign = a.
  - Unsigned ops latch the raw operands.
- Sequencing:
  - The counter loads XLEN. MUL or DIV runs for XLEN cycles (T+1..T+XLEN), then FIX for one cycle (T+XLEN+1).
  - HI/LO are written at the edge ending FIX, then the state returns to IDLE.
  - busy=1 from T+1 through T+XLEN+1, i.e. 33 cycles for XLEN=32.
- MUL: shift-add on a 2*XLEN accumulator. FIX applies two's-complement negation if the sign flag is set. HI = upper half, LO = lower half.
- DIV: restoring division, one quotient bit per cycle. FIX negates the quotient and remainder per their flags. LO = quotient, HI = remainder. Quotient truncates toward zero.
- Signed overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero: detected at T. The unit goes directly to FIX, busy is high for 1 cycle, and HI/LO stay unchanged.
- A new op is accepted in the cycle after busy falls. There is no back-to-back acceptance during FIX.
- Reset mid-operation aborts immediately: IDLE, HI=LO=0.

Optional Feature:
- MULDIV_SINGLE_CYCLE_MUL_EN:
  - Defined: mult/multu use a combinational XLEN×XLEN multiply. HI/LO are written at the edge ending T, busy stays 0, and there is no MUL state.
  - Undefined: the iterative MUL path as above. Div is always iterative.

Decomposition:
- Shared package (mips_pkg): FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO localparams (shared with the ALU control decoder) and the state encoding.
- One natural sub-module: muldiv_iter_core. It holds the accumulator/counter datapath for shift-add and restoring-divide. The top keeps the FSM, HI/LO, and sign handling.

Test Plan:
- mult, a=0xFFFFFFFE (-2), b=3:
  - Iterative build: busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULDIV_SINGLE_CYCLE_MUL_EN build: same HI/LO, busy never rises.
- multu, a=0xFFFFFFFF, b=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- div, a=-7, b=2: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu by zero with HI=0x11, LO=0x22 preloaded via mthi/mtlo: busy for 1 cycle, HI/LO unchanged.
- mflo issued in the cycle after mult is accepted: stall is high for 33 cycles, and on release hilo_rdata equals the new LO.
- Separately, rst_n asserted low at cycle 10 of a div: busy=0 and HI=LO=0 immediately.
